// File: rtl/branch_unit_if.sv
// Bus between the ID-stage comparator, the branch_unit and the IF-stage next-PC mux.
// The branch_unit sits on the slave side; the ID/IF stages drive from the master side.
interface branch_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic             Stall;
    logic             Br_Valid;
    logic [2:0]       Br_Type;
    logic [2:0]       Comp_Out;
    logic [31:0]      PC_ID;
    logic [31:0]      Imm;
    logic             Cnt_Clr;
    logic             Resolved;
    logic             Redirect;
    logic [31:0]      Redirect_PC;
    logic             In_Slot;
    logic [CNT_W-1:0] Taken_Cnt;
    logic [CNT_W-1:0] Total_Cnt;
    logic             Cmp_Err;
    logic             Slot_Err;

    modport slave (
        input  Stall, Br_Valid, Br_Type, Comp_Out, PC_ID, Imm, Cnt_Clr,
        output Resolved, Redirect, Redirect_PC, In_Slot, Taken_Cnt, Total_Cnt, Cmp_Err, Slot_Err
    );

    modport master (
        output Stall, Br_Valid, Br_Type, Comp_Out, PC_ID, Imm, Cnt_Clr,
        input  Resolved, Redirect, Redirect_PC, In_Slot, Taken_Cnt, Total_Cnt, Cmp_Err, Slot_Err
    );
endinterface

// File: rtl/branch_unit.sv
// Registered branch resolution: taken/not-taken decode, redirect target, delay-slot tracking
// and saturating branch statistics. Every output comes straight from a register.
module branch_unit #(
    parameter int unsigned CNT_W = 16
) (
    input logic          clk,
    input logic          reset,
    branch_unit_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StSlot} state_e;

    state_e           state_q;
    logic             resolved_q;
    logic             redirect_q;
    logic [31:0]      redirect_pc_q;
    logic [CNT_W-1:0] taken_cnt_q;
    logic [CNT_W-1:0] total_cnt_q;
    logic             cmp_err_q;
    logic             slot_err_q;

    logic             accept;
    logic             one_hot;
    logic             is_cond;
    logic             cond;
    logic [31:0]      pc4;
    logic [31:0]      target;
    logic [CNT_W-1:0] cnt_max;

    assign cnt_max = '1;
    assign accept  = bus.Br_Valid && !bus.Stall && (state_q == StIdle);
    assign one_hot = (bus.Comp_Out == 3'b100) || (bus.Comp_Out == 3'b010) ||
                     (bus.Comp_Out == 3'b001);
    assign is_cond = !(bus.Br_Type[2] && bus.Br_Type[1]);
    assign pc4     = bus.PC_ID + 32'd4;

    always_comb begin
        cond   = 1'b0;
        target = pc4 + {bus.Imm[29:0], 2'b00};
        case (bus.Br_Type)
            3'b000: cond = bus.Comp_Out[1];
            3'b001: cond = !bus.Comp_Out[1];
            3'b010: cond = bus.Comp_Out[2];
            3'b011: cond = bus.Comp_Out[0] || bus.Comp_Out[1];
            3'b100: cond = bus.Comp_Out[0];
            3'b101: cond = bus.Comp_Out[2] || bus.Comp_Out[1];
            3'b110: begin
                cond   = 1'b1;
                target = {pc4[31:28], bus.Imm[25:0], 2'b00};
            end
            default: begin
                cond   = 1'b0;
                target = pc4 + 32'd4;
            end
        endcase
        // A malformed compare code never produces a taken conditional branch.
        if (is_cond && !one_hot) begin
            cond = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            resolved_q    <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'h0000_0000;
            taken_cnt_q   <= '0;
            total_cnt_q   <= '0;
            cmp_err_q     <= 1'b0;
            slot_err_q    <= 1'b0;
        end else begin
            resolved_q <= 1'b0;
            redirect_q <= 1'b0;
            if (accept) begin
                resolved_q    <= 1'b1;
                redirect_q    <= cond;
                redirect_pc_q <= target;
                state_q       <= StSlot;
                if (is_cond && !one_hot) begin
                    cmp_err_q <= 1'b1;
                end
            end else if (state_q == StSlot && !bus.Stall) begin
                state_q <= StIdle;
                if (bus.Br_Valid) begin
                    slot_err_q <= 1'b1;
                end
            end
            // Clear has priority over counting the branch accepted in the same cycle.
            if (bus.Cnt_Clr) begin
                taken_cnt_q <= '0;
                total_cnt_q <= '0;
            end else if (accept) begin
                if (total_cnt_q != cnt_max) begin
                    total_cnt_q <= total_cnt_q + CNT_W'(1);
                end
                if (cond && taken_cnt_q != cnt_max) begin
                    taken_cnt_q <= taken_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.Resolved    = resolved_q;
    assign bus.Redirect    = redirect_q;
    assign bus.Redirect_PC = redirect_pc_q;
    assign bus.In_Slot     = (state_q == StSlot);
    assign bus.Taken_Cnt   = taken_cnt_q;
    assign bus.Total_Cnt   = total_cnt_q;
    assign bus.Cmp_Err     = cmp_err_q;
    assign bus.Slot_Err    = slot_err_q;
endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: a vector table for decode/target plus short sequences
// for stall, delay slot, counter clear, reset mid-slot and saturation (second instance).
module tb_branch_unit;
    logic clk;
    logic reset;

    branch_unit_if #(.CNT_W(16)) bus ();
    branch_unit_if #(.CNT_W(2))  bus2 ();

    branch_unit #(.CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    branch_unit #(.CNT_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  br_type;
        logic [2:0]  comp;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        redirect;
        logic [31:0] target;
        logic        cmp_err;
    } vec_t;

    vec_t vecs[23];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_total;
    int   exp_taken;
    logic exp_cmp_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [2:0] t, input logic [2:0] c,
                         input logic [31:0] pc, input logic [31:0] imm);
        bus.Br_Valid = valid;
        bus.Br_Type  = t;
        bus.Comp_Out = c;
        bus.PC_ID    = pc;
        bus.Imm      = imm;
    endtask

    initial begin
        // type, comp, pc, imm, redirect, target, sets cmp_err
        vecs[0]  = '{3'b000, 3'b010, 32'h0000_3000, 32'hFFFF_FFFE, 1'b1, 32'h0000_2FFC, 1'b0};
        vecs[1]  = '{3'b000, 3'b100, 32'h0000_1000, 32'h0000_0001, 1'b0, 32'h0000_1008, 1'b0};
        vecs[2]  = '{3'b000, 3'b010, 32'h0000_1000, 32'h0000_0001, 1'b1, 32'h0000_1008, 1'b0};
        vecs[3]  = '{3'b000, 3'b001, 32'h0000_1000, 32'h0000_0001, 1'b0, 32'h0000_1008, 1'b0};
        vecs[4]  = '{3'b001, 3'b100, 32'h0000_1000, 32'h0000_0001, 1'b1, 32'h0000_1008, 1'b0};
        vecs[5]  = '{3'b001, 3'b010, 32'h0000_1000, 32'h0000_0001, 1'b0, 32'h0000_1008, 1'b0};
        vecs[6]  = '{3'b001, 3'b001, 32'h0000_1000, 32'h0000_0001, 1'b1, 32'h0000_1008, 1'b0};
        vecs[7]  = '{3'b010, 3'b100, 32'h0000_1000, 32'h0000_0001, 1'b1, 32'h0000_1008, 1'b0};
        vecs[8]  = '{3'b010, 3'b010, 32'h0000_1000, 32'h0000_0001, 1'b0, 32'h0000_1008, 1'b0};
        vecs[9]  = '{3'b010, 3'b001, 32'h0000_1000, 32'h0000_0001, 1'b0, 32'h0000_1008, 1'b0};
        vecs[10] = '{3'b011, 3'b100, 32'h0000_1000, 32'h0000_0001, 1'b0, 32'h0000_1008, 1'b0};
        vecs[11] = '{3'b011, 3'b010, 32'h0000_1000, 32'h0000_0001, 1'b1, 32'h0000_1008, 1'b0};
        vecs[12] = '{3'b011, 3'b001, 32'h0000_1000, 32'h0000_0001, 1'b1, 32'h0000_1008, 1'b0};
        vecs[13] = '{3'b100, 3'b100, 32'h0000_1000, 32'h0000_0001, 1'b0, 32'h0000_1008, 1'b0};
        vecs[14] = '{3'b100, 3'b010, 32'h0000_1000, 32'h0000_0001, 1'b0, 32'h0000_1008, 1'b0};
        vecs[15] = '{3'b100, 3'b001, 32'h0000_1000, 32'h0000_0001, 1'b1, 32'h0000_1008, 1'b0};
        vecs[16] = '{3'b101, 3'b100, 32'h0000_1000, 32'h0000_0001, 1'b1, 32'h0000_1008, 1'b0};
        vecs[17] = '{3'b101, 3'b010, 32'h0000_1000, 32'h0000_0001, 1'b1, 32'h0000_1008, 1'b0};
        vecs[18] = '{3'b101, 3'b001, 32'h0000_1000, 32'h0000_0001, 1'b0, 32'h0000_1008, 1'b0};
        vecs[19] = '{3'b110, 3'b000, 32'h0000_3FFC, 32'h0000_0010, 1'b1, 32'h0000_0040, 1'b0};
        vecs[20] = '{3'b000, 3'b010, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0};
        vecs[21] = '{3'b111, 3'b010, 32'h0000_2000, 32'h0000_0005, 1'b0, 32'h0000_2008, 1'b0};
        vecs[22] = '{3'b000, 3'b000, 32'h0000_1000, 32'h0000_0001, 1'b0, 32'h0000_1008, 1'b1};

        reset = 1'b1;
        drive(1'b0, 3'b000, 3'b000, 32'h0, 32'h0);
        bus.Stall    = 1'b0;
        bus.Cnt_Clr  = 1'b0;
        bus2.Stall   = 1'b0;
        bus2.Cnt_Clr = 1'b0;
        bus2.Br_Valid = 1'b0;
        bus2.Br_Type  = 3'b110;
        bus2.Comp_Out = 3'b000;
        bus2.PC_ID    = 32'h0000_0100;
        bus2.Imm      = 32'h0000_0020;
        step();
        step();
        chk("rst_resolved", 32'(bus.Resolved), 32'd0);
        chk("rst_redirect_pc", bus.Redirect_PC, 32'h0);
        chk("rst_in_slot", 32'(bus.In_Slot), 32'd0);
        chk("rst_total", 32'(bus.Total_Cnt), 32'd0);
        reset = 1'b0;

        exp_total   = 0;
        exp_taken   = 0;
        exp_cmp_err = 1'b0;
        for (int i = 0; i < 23; i++) begin
            drive(1'b1, vecs[i].br_type, vecs[i].comp, vecs[i].pc, vecs[i].imm);
            step();
            exp_total++;
            if (vecs[i].redirect) exp_taken++;
            if (vecs[i].cmp_err) exp_cmp_err = 1'b1;
            chk($sformatf("v%0d_resolved", i), 32'(bus.Resolved), 32'd1);
            chk($sformatf("v%0d_redirect", i), 32'(bus.Redirect), 32'(vecs[i].redirect));
            chk($sformatf("v%0d_target", i), bus.Redirect_PC, vecs[i].target);
            chk($sformatf("v%0d_in_slot", i), 32'(bus.In_Slot), 32'd1);
            chk($sformatf("v%0d_total", i), 32'(bus.Total_Cnt), 32'(exp_total));
            chk($sformatf("v%0d_taken", i), 32'(bus.Taken_Cnt), 32'(exp_taken));
            chk($sformatf("v%0d_cmp_err", i), 32'(bus.Cmp_Err), 32'(exp_cmp_err));
            bus.Br_Valid = 1'b0;
            step();
            chk($sformatf("v%0d_idle_resolved", i), 32'(bus.Resolved), 32'd0);
            chk($sformatf("v%0d_idle_redirect", i), 32'(bus.Redirect), 32'd0);
            chk($sformatf("v%0d_idle_in_slot", i), 32'(bus.In_Slot), 32'd0);
            chk($sformatf("v%0d_hold_pc", i), bus.Redirect_PC, vecs[i].target);
        end

        // Branch held under stall: nothing happens until the stall lifts.
        drive(1'b1, 3'b000, 3'b010, 32'h0000_0200, 32'h0000_0004);
        bus.Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_no_pulse", 32'(bus.Resolved), 32'd0);
            chk("stall_no_slot", 32'(bus.In_Slot), 32'd0);
        end
        bus.Stall = 1'b0;
        step();
        exp_total++;
        exp_taken++;
        chk("release_resolved", 32'(bus.Resolved), 32'd1);
        chk("release_target", bus.Redirect_PC, 32'h0000_0214);
        chk("release_total", 32'(bus.Total_Cnt), 32'(exp_total));
        bus.Br_Valid = 1'b0;
        bus.Stall    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("slot_stall_in_slot", 32'(bus.In_Slot), 32'd1);
            chk("slot_stall_no_pulse", 32'(bus.Resolved), 32'd0);
        end
        bus.Stall = 1'b0;
        step();
        chk("slot_leave", 32'(bus.In_Slot), 32'd0);

        // Branch presented in the delay slot.
        drive(1'b1, 3'b110, 3'b000, 32'h0000_0300, 32'h0000_0080);
        step();
        exp_total++;
        exp_taken++;
        chk("pre_slot_err", 32'(bus.Slot_Err), 32'd0);
        drive(1'b1, 3'b110, 3'b000, 32'h0000_0304, 32'h0000_0100);
        step();
        chk("slot_err_set", 32'(bus.Slot_Err), 32'd1);
        chk("slot_br_no_pulse", 32'(bus.Resolved), 32'd0);
        chk("slot_br_total", 32'(bus.Total_Cnt), 32'(exp_total));
        chk("slot_br_taken", 32'(bus.Taken_Cnt), 32'(exp_taken));
        chk("slot_br_pc_hold", bus.Redirect_PC, 32'h0000_0200);
        chk("slot_br_idle", 32'(bus.In_Slot), 32'd0);
        bus.Br_Valid = 1'b0;
        step();
        chk("slot_err_sticky", 32'(bus.Slot_Err), 32'd1);

        // Clear coincident with an accept.
        drive(1'b1, 3'b000, 3'b010, 32'h0000_0400, 32'h0000_0002);
        bus.Cnt_Clr = 1'b1;
        step();
        bus.Cnt_Clr = 1'b0;
        chk("clr_resolved", 32'(bus.Resolved), 32'd1);
        chk("clr_redirect", 32'(bus.Redirect), 32'd1);
        chk("clr_target", bus.Redirect_PC, 32'h0000_040C);
        chk("clr_total", 32'(bus.Total_Cnt), 32'd0);
        chk("clr_taken", 32'(bus.Taken_Cnt), 32'd0);
        chk("cmp_err_sticky", 32'(bus.Cmp_Err), 32'd1);

        // Reset while the delay slot is in ID, with a branch present.
        drive(1'b1, 3'b110, 3'b000, 32'h0000_0500, 32'h0000_0040);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.Br_Valid = 1'b0;
        chk("rslot_resolved", 32'(bus.Resolved), 32'd0);
        chk("rslot_redirect", 32'(bus.Redirect), 32'd0);
        chk("rslot_pc", bus.Redirect_PC, 32'h0);
        chk("rslot_in_slot", 32'(bus.In_Slot), 32'd0);
        chk("rslot_cmp_err", 32'(bus.Cmp_Err), 32'd0);
        chk("rslot_slot_err", 32'(bus.Slot_Err), 32'd0);
        chk("rslot_total", 32'(bus.Total_Cnt), 32'd0);
        step();
        bus.Br_Valid = 1'b1;
        step();
        bus.Br_Valid = 1'b0;
        chk("post_rst_resolved", 32'(bus.Resolved), 32'd1);
        chk("post_rst_target", bus.Redirect_PC, 32'h0000_0100);
        chk("post_rst_total", 32'(bus.Total_Cnt), 32'd1);

        // Saturation with 2-bit counters: five taken jumps.
        for (int i = 0; i < 5; i++) begin
            bus2.Br_Valid = 1'b1;
            step();
            bus2.Br_Valid = 1'b0;
            step();
        end
        chk("sat_taken", 32'(bus2.Taken_Cnt), 32'd3);
        chk("sat_total", 32'(bus2.Total_Cnt), 32'd3);
        chk("sat_target", bus2.Redirect_PC, 32'h0000_0080);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/branch_unit.md
# branch_unit

Registered branch-resolution stage for the five-stage pipeline. It consumes the one-hot compare code {gt, eq, lt} produced for the two register operands in ID, together with the branch type, and resolves taken/not-taken. It computes the redirect target, tracks the MIPS delay slot, and keeps saturating branch statistics. It sits between the ID-stage comparator and the IF-stage next-PC mux.

## Interface
- CNT_W, 16, width of the statistic counters
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high
- Stall  in  1  ID stage frozen this cycle
- Br_Valid  in  1  instruction in ID is a branch or jump
- Br_Type  in  3  000 beq, 001 bne, 010 bgtz, 011 blez, 100 bltz, 101 bgez, 110 j (always), 111 reserved (never)
- Comp_Out  in  3  one-hot compare code: 100 gt, 010 eq, 001 lt
- PC_ID  in  32  PC of the instruction in ID
- Imm  in  32  beq–bgez: sign-extended word offset; j: bits [25:0] = instr_index
- Cnt_Clr  in  1  synchronous clear of both counters
- Resolved  out  1  one-cycle pulse: a branch was accepted on the previous edge
- Redirect  out  1  one-cycle pulse: accepted branch is taken
- Redirect_PC  out  32  target of the last accepted branch
- In_Slot  out  1  delay-slot instruction is currently in ID
- Taken_Cnt  out  CNT_W  accepted branches that were taken, saturating
- Total_Cnt  out  CNT_W  accepted branches, saturating
- Cmp_Err  out  1  sticky: accepted conditional branch saw a non-one-hot Comp_Out
- Slot_Err  out  1  sticky: branch presented in a delay slot

## Operation
- Accept condition: Br_Valid && !Stall && state IDLE.
- Condition decode:
  - beq = eq; bne = !eq; bgtz = gt; blez = lt|eq; bltz = lt; bgez = gt|eq
  - j = 1; 111 = 0
- Illegal compare code: Comp_Out not exactly one-hot (000, 011, 101, 110, 111) on an accepted conditional branch (types 000–101).
  - Branch resolves not-taken.
  - Cmp_Err set; held until reset.
- Target:
  - Types 000–101: PC_ID + 4 + (Imm << 2), modulo 2^32 (wrap-around permitted).
  - Type 110: {PC4[31:28], Imm[25:0], 2'b00}, where PC4 = PC_ID + 4.
  - Type 111: target is PC_ID + 8.
- On accept, the next edge sets:
  - Resolved = 1
  - Redirect = cond
  - Redirect_PC = target, loaded even when not taken
  - Total_Cnt += 1
  - Taken_Cnt += cond
  - state -> SLOT
- When no branch is accepted, Resolved and Redirect are 0 after the edge. Redirect_PC holds its value.
- Delay-slot FSM, states IDLE and SLOT:
  - IDLE -> SLOT on accept.
  - SLOT -> IDLE on the first edge with !Stall (the delay-slot instruction leaves ID).
  - SLOT with Stall: remain in SLOT.
  - SLOT with Br_Valid && !Stall: branch ignored (no pulse, no count), Slot_Err set sticky, SLOT -> IDLE.
  - In_Slot = (state == SLOT).
- Counters saturate at 2^CNT_W − 1; an increment at max holds max.

## Timing
- Latency: one cycle from the accept edge to the Resolved/Redirect pulse. No combinational path from inputs to outputs.
- Back-to-back: a branch at cycle T sets SLOT; the earliest next accept is at T+2 (T+1 is the delay slot).
- Stall && Br_Valid simultaneously: no accept, outputs behave as an idle cycle, state unchanged.
- Cnt_Clr together with an accepted branch:
  - Clear wins; both counters become 0 and this branch is not counted.
  - Resolved, Redirect and Redirect_PC update normally.
- Reset (any state, including mid-SLOT) at the edge sets:
  - All outputs to 0 (Redirect_PC = 32'h0000_0000).
  - State to IDLE; counters and sticky errors cleared.
  - A Br_Valid present in the reset cycle is ignored.

## Test plan
- beq taken: PC_ID=32'h0000_3000, Imm=32'hFFFF_FFFE, Comp_Out=010, Br_Valid=1.
  - Next cycle: Resolved=1, Redirect=1, Redirect_PC=32'h0000_2FFC, In_Slot=1, Total_Cnt=1, Taken_Cnt=1.
  - Following cycle: In_Slot=0.
- Condition sweep: each of types 000–101 against each of Comp_Out 100/010/001 matches the decode table.
  - Example: blez with 100 gives Redirect=0; bgez with 010 gives Redirect=1.
- Jump and wrap-around:
  - Type 110, PC_ID=32'h0000_3FFC, Imm=32'h0000_0010: Redirect_PC=32'h0000_0040.
  - beq at PC_ID=32'hFFFF_FFFC, Imm=0, Comp_Out=010: Redirect_PC=32'h0000_0000.
- Stall and delay slot:
  - Br_Valid held with Stall=1 for 3 cycles: no pulse.
  - Release: one pulse; then Stall=1 for 2 cycles keeps In_Slot=1.
  - A branch presented in the slot with !Stall: Slot_Err=1, no pulse, counts unchanged.
- Errors and saturation:
  - beq with Comp_Out=000: Redirect=0, Cmp_Err=1 until reset.
  - CNT_W=2: five taken branches leave Taken_Cnt=3 and Total_Cnt=3.
  - Cnt_Clr coincident with an accepted branch: counters 0, Resolved=1.
- Reset mid-SLOT: reset asserted while In_Slot=1 gives all outputs 0 next cycle; a branch two cycles after reset is accepted normally.
